// File: rtl/alu_pkt_engine_if.sv
// Byte-stream bus of alu_pkt_engine: RX byte strobe in, TX valid/ready out,
// plus busy/error status.
interface alu_pkt_engine_if;
   logic [7:0] rx_data_i;
   logic       rx_valid_i;
   logic [7:0] tx_data_o;
   logic       tx_valid_o;
   logic       tx_ready_i;
   logic       busy_o;
   logic       err_o;

   // master: byte source / TX sink; slave: the packet engine
   modport master (
      output rx_data_i, rx_valid_i, tx_ready_i,
      input  tx_data_o, tx_valid_o, busy_o, err_o
   );

   modport slave (
      input  rx_data_i, rx_valid_i, tx_ready_i,
      output tx_data_o, tx_valid_o, busy_o, err_o
   );
endinterface

// File: rtl/alu_pkt_engine.sv
// Packet engine: parses opcode/rsvd/len header from an RX byte stream and runs
// ECHO, 32-bit ADD or XOR over the payload, returning bytes on a valid/ready TX port.
module alu_pkt_engine #(
   parameter logic [7:0] OP_ECHO = 8'hEC,
   parameter logic [7:0] OP_ADD  = 8'hAD,
   parameter logic [7:0] OP_XOR  = 8'h3C
) (
   input  logic             clk_i,
   input  logic             rst_i,
   alu_pkt_engine_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_ECHO, S_ACCUM, S_SEND, S_DRAIN
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [7:0]  len_lo_q, len_lo_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic [31:0] acc_q, acc_d;
   logic [31:0] word_q, word_d;
   logic [1:0]  bidx_q, bidx_d;
   logic        pend_q, pend_d;
   logic [1:0]  sidx_q, sidx_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        err_q, err_d;
   logic        busy_q;

   logic        rx;
   logic        hs;
   logic [15:0] len_full;
   logic [15:0] len_pay;
   logic [31:0] acc_apply;
   logic [1:0]  sidx_n;

   assign rx        = bus.rx_valid_i;
   assign hs        = tx_valid_q & bus.tx_ready_i;
   assign len_full  = {bus.rx_data_i, len_lo_q};
   assign len_pay   = len_full - 16'd4;
   assign acc_apply = (opcode_q == OP_ADD) ? (acc_q + word_q) : (acc_q ^ word_q);
   assign sidx_n    = sidx_q + 2'd1;

   // NOTE: every *_d gets its hold value first so no path through this block
   // can leave a signal unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      opcode_d   = opcode_q;
      len_lo_d   = len_lo_q;
      pcnt_d     = pcnt_q;
      acc_d      = acc_q;
      word_d     = word_q;
      bidx_d     = bidx_q;
      pend_d     = pend_q;
      sidx_d     = sidx_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      err_d      = 1'b0;

      case (state_q)
         S_IDLE: if (rx) begin
            opcode_d = bus.rx_data_i;
            acc_d    = '0;
            bidx_d   = '0;
            pend_d   = 1'b0;
            state_d  = S_RSVD;
         end

         S_RSVD: if (rx) state_d = S_LEN_LO;

         S_LEN_LO: if (rx) begin
            len_lo_d = bus.rx_data_i;
            state_d  = S_LEN_HI;
         end

         S_LEN_HI: if (rx) begin
            pcnt_d = len_pay;
            if (len_full < 16'd4) begin
               pcnt_d  = '0;
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else if (opcode_q == OP_ECHO) begin
               state_d = (len_pay == 16'd0) ? S_IDLE : S_ECHO;
            end else if (opcode_q == OP_ADD || opcode_q == OP_XOR) begin
               if (len_pay == 16'd0 || len_pay[1:0] != 2'd0) begin
                  err_d   = 1'b1;
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_ACCUM;
               end
            end else begin
               err_d   = 1'b1;
               state_d = S_DRAIN;
            end
         end

         S_ECHO: begin
            if (hs) tx_valid_d = 1'b0;
            if (rx) begin
               // The holding register frees up on the same edge it is accepted.
               if (pcnt_q != 16'd0 && (!tx_valid_q || bus.tx_ready_i)) begin
                  tx_data_d  = bus.rx_data_i;
                  tx_valid_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               if (pcnt_q != 16'd0) pcnt_d = pcnt_q - 16'd1;
            end
            if (pcnt_d == 16'd0 && !tx_valid_d) state_d = S_IDLE;
         end

         S_ACCUM: begin
            if (pend_q) begin
               acc_d  = acc_apply;
               pend_d = 1'b0;
               if (pcnt_q == 16'd0) begin
                  tx_data_d  = acc_apply[7:0];
                  tx_valid_d = 1'b1;
                  sidx_d     = '0;
                  state_d    = S_SEND;
               end
            end
            if (rx) begin
               if (pcnt_q != 16'd0) begin
                  word_d[{bidx_q, 3'b000} +: 8] = bus.rx_data_i;
                  bidx_d = bidx_q + 2'd1;
                  pcnt_d = pcnt_q - 16'd1;
                  if (bidx_q == 2'd3) pend_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         S_SEND: begin
            if (rx) err_d = 1'b1;
            if (hs) begin
               if (sidx_q == 2'd3) begin
                  tx_valid_d = 1'b0;
                  state_d    = S_IDLE;
               end else begin
                  sidx_d    = sidx_n;
                  tx_data_d = acc_q[{sidx_n, 3'b000} +: 8];
               end
            end
         end

         S_DRAIN: begin
            if (pcnt_q == 16'd0) begin
               state_d = S_IDLE;
            end else if (rx) begin
               pcnt_d = pcnt_q - 16'd1;
               if (pcnt_q == 16'd1) state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update from the same pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         opcode_q   <= '0;
         len_lo_q   <= '0;
         pcnt_q     <= '0;
         acc_q      <= '0;
         word_q     <= '0;
         bidx_q     <= '0;
         pend_q     <= 1'b0;
         sidx_q     <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         opcode_q   <= opcode_d;
         len_lo_q   <= len_lo_d;
         pcnt_q     <= pcnt_d;
         acc_q      <= acc_d;
         word_q     <= word_d;
         bidx_q     <= bidx_d;
         pend_q     <= pend_d;
         sidx_q     <= sidx_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         err_q      <= err_d;
         busy_q     <= (state_d != S_IDLE);
      end
   end

   assign bus.tx_data_o  = tx_data_q;
   assign bus.tx_valid_o = tx_valid_q;
   assign bus.err_o      = err_q;
   assign bus.busy_o     = busy_q;

endmodule

// File: tb/tb_alu_pkt_engine.sv
// Self-checking bench for alu_pkt_engine: directed packets plus random packets
// scored against a packet-level model of ECHO/ADD/XOR.
module tb_alu_pkt_engine;

   localparam logic [7:0] OP_ECHO = 8'hEC;
   localparam logic [7:0] OP_ADD  = 8'hAD;
   localparam logic [7:0] OP_XOR  = 8'h3C;

   logic clk;
   logic rst;
   alu_pkt_engine_if bus ();

   alu_pkt_engine dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   int         n_vec = 0;
   int         n_err = 0;
   int         ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
   int         gap_max = 2;
   int         err_cnt = 0;
   int         exp_err = 0;
   logic [7:0] pay_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] tx_q[$];
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // TX sink and err counter; also verifies data/valid hold while stalled.
   always @(negedge clk) begin
      if (!rst) begin
         if (prev_stall) begin
            check("hold_valid", {31'd0, bus.tx_valid_o}, 32'd1);
            check("hold_data", {24'd0, bus.tx_data_o}, {24'd0, prev_data});
         end
         case (ready_mode)
            0:       bus.tx_ready_i = 1'b1;
            1:       bus.tx_ready_i = 1'($urandom_range(1, 0));
            default: bus.tx_ready_i = 1'b0;
         endcase
         if (bus.tx_valid_o && bus.tx_ready_i) tx_q.push_back(bus.tx_data_o);
         if (bus.err_o) err_cnt++;
         prev_stall = bus.tx_valid_o && !bus.tx_ready_i;
         prev_data  = bus.tx_data_o;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Packet-level reference: what the engine should return for a whole packet.
   task automatic model_pkt(input logic [7:0] op, input logic [15:0] len);
      int          pc;
      logic [31:0] acc;
      logic [31:0] w;
      exp_q.delete();
      exp_err = 0;
      if (len < 16'd4) begin
         exp_err = 1;
      end else begin
         pc = int'(len) - 4;
         if (op == OP_ECHO) begin
            foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
         end else if (op == OP_ADD || op == OP_XOR) begin
            if (pc == 0 || pc % 4 != 0) begin
               exp_err = 1;
            end else begin
               acc = 32'd0;
               for (int i = 0; i < pc / 4; i++) begin
                  w = {pay_q[4*i+3], pay_q[4*i+2], pay_q[4*i+1], pay_q[4*i]};
                  acc = (op == OP_ADD) ? acc + w : acc ^ w;
               end
               for (int b = 0; b < 4; b++) exp_q.push_back(8'(acc >> (8 * b)));
            end
         end else begin
            exp_err = 1;
         end
      end
   endtask

   // Caller must be sitting just after a negedge.
   task automatic send_byte(input logic [7:0] b);
      bus.rx_data_i  = b;
      bus.rx_valid_i = 1'b1;
      @(negedge clk);
      bus.rx_valid_i = 1'b0;
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
   endtask

   task automatic send_pkt(input logic [7:0] op, input logic [15:0] len);
      tx_q.delete();
      err_cnt = 0;
      model_pkt(op, len);
      @(negedge clk);
      send_byte(op);
      send_byte(8'h00);
      send_byte(len[7:0]);
      send_byte(len[15:8]);
      foreach (pay_q[i]) send_byte(pay_q[i]);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (bus.busy_o && n < 3000);
      if (bus.busy_o) check({tag, "_idle_timeout"}, {31'd0, bus.busy_o}, 32'd0);
   endtask

   task automatic finish_pkt(input string tag);
      wait_idle(tag);
      repeat (3) @(negedge clk);
      check({tag, "_tx_cnt"}, tx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
         check($sformatf("%s_tx%0d", tag, i), {24'd0, tx_q[i]}, {24'd0, exp_q[i]});
      check({tag, "_err"}, err_cnt, exp_err);
   endtask

   task automatic set_pay(input logic [31:0] w0, input logic [31:0] w1, input int n);
      pay_q.delete();
      for (int i = 0; i < n; i++)
         pay_q.push_back(i < 4 ? 8'(w0 >> (8 * i)) : 8'(w1 >> (8 * (i - 4))));
   endtask

   initial begin
      logic [7:0]  op;
      logic [15:0] len;
      int          pc;
      int          sel;

      rst            = 1'b0;
      bus.rx_data_i  = '0;
      bus.rx_valid_i = 1'b0;
      bus.tx_ready_i = 1'b0;
      #5 rst = 1'b1;
      #1;
      check("rst_tx_valid", {31'd0, bus.tx_valid_o}, 32'd0);
      check("rst_tx_data", {24'd0, bus.tx_data_o}, 32'd0);
      check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
      check("rst_err", {31'd0, bus.err_o}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // ECHO 41 42; busy must drop with the second handshake
      ready_mode = 0;
      pay_q = '{8'h41, 8'h42};
      send_pkt(OP_ECHO, 16'd6);
      wait_idle("echo");
      check("echo_busy_fall", tx_q.size(), 2);
      finish_pkt("echo");

      // ADD wrap, ADD small, XOR
      ready_mode = 1;
      set_pay(32'h0000_0001, 32'hFFFF_FFFF, 8);
      send_pkt(OP_ADD, 16'd12);
      finish_pkt("add_wrap");
      set_pay(32'h0000_0002, 32'h0000_0003, 8);
      send_pkt(OP_ADD, 16'd12);
      finish_pkt("add");
      set_pay(32'h55AA_0FF0, 32'h0000_FFFF, 8);
      send_pkt(OP_XOR, 16'd12);
      finish_pkt("xor");

      // Backpressure in SEND, with a stray RX byte that must be dropped
      ready_mode = 2;
      set_pay(32'h1234_5678, 32'h0101_0101, 8);
      send_pkt(OP_ADD, 16'd12);
      for (int i = 0; i < 50 && !bus.tx_valid_o; i++) @(negedge clk);
      check("bp_valid", {31'd0, bus.tx_valid_o}, 32'd1);
      repeat (5) @(negedge clk);
      send_byte(8'h77);
      exp_err++;
      repeat (6) @(negedge clk);
      ready_mode = 1;
      finish_pkt("bp");

      // ECHO holding register overrun: 2 of 3 bytes dropped
      ready_mode = 2;
      gap_max = 0;
      pay_q = '{8'hA1, 8'hA2, 8'hA3};
      send_pkt(OP_ECHO, 16'd7);
      exp_q = '{8'hA1};
      exp_err = 2;
      repeat (3) @(negedge clk);
      ready_mode = 0;
      finish_pkt("echo_ovr");
      gap_max = 2;

      // Protocol errors
      pay_q = '{8'h11, 8'h22};
      send_pkt(8'h55, 16'd6);
      finish_pkt("bad_op");
      pay_q = '{8'h99};
      send_pkt(OP_ECHO, 16'd5);
      finish_pkt("echo_after_err");
      pay_q = '{8'h7E};
      send_pkt(OP_ADD, 16'd5);
      finish_pkt("add_len5");
      pay_q.delete();
      send_pkt(OP_ADD, 16'd2);
      finish_pkt("len2");
      pay_q.delete();
      send_pkt(OP_ECHO, 16'd4);
      finish_pkt("echo_len4");

      // Reset in the middle of ACCUM
      ready_mode = 1;
      pay_q.delete();
      @(negedge clk);
      send_byte(OP_ADD);
      send_byte(8'h00);
      send_byte(8'h10);
      send_byte(8'h00);
      for (int i = 0; i < 6; i++) send_byte(8'(8'hF0 + i));
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_tx_valid", {31'd0, bus.tx_valid_o}, 32'd0);
      check("mid_rst_tx_data", {24'd0, bus.tx_data_o}, 32'd0);
      check("mid_rst_busy", {31'd0, bus.busy_o}, 32'd0);
      check("mid_rst_err", {31'd0, bus.err_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      set_pay(32'h8000_0000, 32'h8000_0005, 8);
      send_pkt(OP_ADD, 16'd12);
      finish_pkt("add_after_rst");

      // Sparse byte arrival, as from a slow serial link
      gap_max = 40;
      pay_q = '{8'h5A, 8'hC3, 8'h00};
      send_pkt(OP_ECHO, 16'd7);
      finish_pkt("echo_sparse");
      gap_max = 2;

      // Random packets
      for (int n = 0; n < 30; n++) begin
         sel = $urandom_range(4, 0);
         case (sel)
            0: begin op = OP_ECHO; pc = $urandom_range(8, 1); end
            1: begin op = OP_ADD;  pc = 4 * $urandom_range(4, 1); end
            2: begin op = OP_XOR;  pc = 4 * $urandom_range(4, 1); end
            3: begin op = 8'($urandom_range(255, 0)); pc = $urandom_range(6, 0); end
            default: begin
               op = ($urandom_range(1, 0) != 0) ? OP_ADD : OP_XOR;
               pc = $urandom_range(9, 0);
               if (pc % 4 == 0 && pc != 0) pc = pc + 1;
            end
         endcase
         if (op == OP_ECHO || op == OP_ADD || op == OP_XOR) begin
            if (sel == 3) op = 8'h01;
         end
         len = 16'(pc + 4);
         if ($urandom_range(7, 0) == 0) begin
            len = 16'($urandom_range(3, 0));
            pc  = 0;
         end
         pay_q.delete();
         for (int i = 0; i < pc; i++) pay_q.push_back(8'($urandom_range(255, 0)));
         ready_mode = (op == OP_ECHO) ? 0 : 1;
         send_pkt(op, len);
         finish_pkt($sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
